// File: rtl/vga_scan_driver.sv
// VGA raster generator: drives col/row to the scene mux, delays de/sync to
// match the scene read latency, and registers rgb/sync onto the board pins.
module vga_scan_driver #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 56,
  parameter int H_SYNC   = 120,
  parameter int H_BP     = 64,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 37,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 23,
  parameter bit SYNC_POL = 1'b1,
  parameter int RD_LAT   = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [11:0] pix_rgb,
  output logic [9:0]  col,
  output logic [9:0]  row,
  output logic        de,
  output logic        frame_start,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int SR_W    = (RD_LAT > 0) ? RD_LAT : 1;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;
  logic        in_view;
  logic        hs_act;
  logic        vs_act;
  logic        de_d;
  logic        hs_d;
  logic        vs_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 11'd1;
    end
  end

  // rstn gates the address side so de/frame_start read 0 while reset is held,
  // even though the counters already sit at 0/0.
  assign in_view     = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign de          = rstn && in_view;
  assign col         = de ? h_cnt[9:0] : '0;
  assign row         = de ? v_cnt : '0;
  assign frame_start = rstn && (h_cnt == '0) && (v_cnt == '0);

  // Sync flags are kept active-high internally; polarity is applied at the pins.
  assign hs_act = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign vs_act = (v_cnt >= VS_BEG) && (v_cnt < VS_END);

  generate
    if (RD_LAT == 0) begin : g_no_lat
      assign de_d = de;
      assign hs_d = hs_act;
      assign vs_d = vs_act;
    end else begin : g_lat
      logic [SR_W-1:0] de_sr;
      logic [SR_W-1:0] hs_sr;
      logic [SR_W-1:0] vs_sr;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          de_sr <= '0;
          hs_sr <= '0;
          vs_sr <= '0;
        end else begin
          de_sr[0] <= de;
          hs_sr[0] <= hs_act;
          vs_sr[0] <= vs_act;
          for (int i = 1; i < SR_W; i++) begin
            de_sr[i] <= de_sr[i-1];
            hs_sr[i] <= hs_sr[i-1];
            vs_sr[i] <= vs_sr[i-1];
          end
        end
      end

      assign de_d = de_sr[SR_W-1];
      assign hs_d = hs_sr[SR_W-1];
      assign vs_d = vs_sr[SR_W-1];
    end
  endgenerate

  // pix_rgb is muxed away outside the visible area so X from the scene never reaches the pins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      {vga_r, vga_g, vga_b} <= 12'h000;
      vga_hs                <= ~SYNC_POL;
      vga_vs                <= ~SYNC_POL;
    end else begin
      {vga_r, vga_g, vga_b} <= de_d ? pix_rgb : 12'h000;
      vga_hs                <= SYNC_POL ? hs_d : ~hs_d;
      vga_vs                <= SYNC_POL ? vs_d : ~vs_d;
    end
  end

endmodule

// File: tb/tb_vga_scan_driver.sv
// Bench for vga_scan_driver on a shrunken raster; the reference derives the scan
// position from the cycle count since reset release and predicts every output.
module tb_vga_scan_driver;

  localparam int HA = 40, HFP = 4, HSW = 6, HBP = 5;
  localparam int VA = 20, VFP = 2, VSW = 3, VBP = 2;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FT = HT * VT;
  localparam int RL = 1;
  localparam bit SP = 1'b1;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [11:0] pix_rgb = 12'h000;
  logic [9:0]  col, row;
  logic        de, frame_start, vga_hs, vga_vs;
  logic [3:0]  vga_r, vga_g, vga_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  logic [21:0] scan_q[$];
  logic [13:0] exp_q[$];

  vga_scan_driver #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .SYNC_POL(SP), .RD_LAT(RL)
  ) dut (
    .clk(clk), .rstn(rstn), .pix_rgb(pix_rgb),
    .col(col), .row(row), .de(de), .frame_start(frame_start),
    .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic bit vis(input int t);
    int h, v;
    h = t % HT;
    v = (t / HT) % VT;
    return (h < HA) && (v < VA);
  endfunction

  function automatic logic [21:0] scan_exp(input int t);
    int h, v;
    bit d;
    h = t % HT;
    v = (t / HT) % VT;
    d = vis(t);
    return {(h == 0 && v == 0), d, d ? 10'(h) : 10'd0, d ? 10'(v) : 10'd0};
  endfunction

  function automatic logic [11:0] rom(input int t);
    logic [21:0] s;
    s = scan_exp(t);
    return {s[13:10], s[3:0], 4'hA};
  endfunction

  function automatic logic [13:0] pin_exp(input int t, input logic [11:0] p);
    int h, v;
    bit hs, vs;
    h = t % HT;
    v = (t / HT) % VT;
    hs = (h >= HA + HFP) && (h < HA + HFP + HSW);
    vs = (v >= VA + VFP) && (v < VA + VFP + VSW);
    return {SP ? hs : ~hs, SP ? vs : ~vs, vis(t) ? p : 12'h000};
  endfunction

  function automatic logic [13:0] pin_blank();
    return {~SP, ~SP, 12'h000};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (scan_q.size() == 0) begin
        errors++;
        $display("FAIL scan cycle %0d: no expectation queued", cyc);
      end else begin
        logic [21:0] es;
        es = scan_q.pop_front();
        if ({frame_start, de, col, row} !== es) begin
          errors++;
          $display("FAIL scan cycle %0d: got fs=%b de=%b col=%0d row=%0d, expected fs=%b de=%b col=%0d row=%0d",
                   cyc, frame_start, de, col, row, es[21], es[20], es[19:10], es[9:0]);
        end
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pins cycle %0d: no expectation queued", cyc);
      end else begin
        logic [13:0] ep;
        ep = exp_q.pop_front();
        if ({vga_hs, vga_vs, vga_r, vga_g, vga_b} !== ep) begin
          errors++;
          $display("FAIL pins cycle %0d: got hs=%b vs=%b rgb=%h, expected hs=%b vs=%b rgb=%h",
                   cyc, vga_hs, vga_vs, {vga_r, vga_g, vga_b}, ep[13], ep[12], ep[11:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({frame_start, de, col, row} !== 22'd0 ||
        {vga_hs, vga_vs, vga_r, vga_g, vga_b} !== pin_blank()) begin
      errors++;
      $display("FAIL %s: got fs=%b de=%b col=%0d row=%0d hs=%b vs=%b rgb=%h, expected all 0 with sync=%b",
               tag, frame_start, de, col, row, vga_hs, vga_vs, {vga_r, vga_g, vga_b}, ~SP);
    end
  endtask

  // mode 0: ROM for frame 0, constant FFF for frame 1, random for frame 2 (cycling)
  task automatic run_seg(input int n_cycles);
    logic [11:0] p;
    int m;
    @(posedge clk);
    #1 rstn = 1'b1;
    exp_q.push_back(pin_blank());
    for (int c = 0; c < n_cycles; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      cyc = c;
      m = (c / FT) % 3;
      if (m == 1) p = 12'hFFF;
      else if (m == 0 && c >= RL) p = rom(c - RL);
      else p = 12'($urandom_range(0, 4095));
      pix_rgb = p;
      scan_q.push_back(scan_exp(c));
      exp_q.push_back((c - RL >= 0) ? pin_exp(c - RL, p) : pin_blank());
      mon_en = 1'b1;
    end
    @(negedge clk);
    #1 mon_en = 1'b0;
    scan_q.delete();
    exp_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #2 check_reset_outputs("reset_hold");

    // three frames then a mid-frame reset at line 10, column 17
    run_seg(3 * FT + 10 * HT + 17);
    rstn = 1'b0;
    #1 check_reset_outputs("midframe_reset_immediate");
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("midframe_reset_held");

    run_seg(FT + 2 * HT);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
